// File: rtl/adc_fe_pkg.sv
// Shared constants and FSM state type for the ADC trigger front end.
package adc_fe_pkg;

    localparam int unsigned DEF_PERIOD_WIDTH = 16;
    localparam int unsigned DEF_TOL          = 2;
    localparam int unsigned DEF_STABLE_COUNT = 4;
    localparam int unsigned DEF_MIN_PERIOD   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StTracking,
        StLocked
    } fe_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous inputs into the clk domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    // Metastability flop followed by the output flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/adc_trigger_frontend.sv
// ADC sample capture plus comparator period measurement and frequency-lock detection.
module adc_trigger_frontend
    import adc_fe_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int unsigned TOL          = DEF_TOL,
    parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    adc_clk,
    input  logic [11:0]             adc_data,
    input  logic                    signal_in,
    output logic [11:0]             sync_adc_data,
    output logic                    sync_signal_in,
    output logic                    stable,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid
);

    localparam int unsigned MCW = $clog2(STABLE_COUNT + 1);

    logic                    adc_clk_prev_q;
    logic                    sig_prev_q;
    logic                    rise;
    fe_state_e               state_q, state_d;
    logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
    logic [PERIOD_WIDTH-1:0] ref_q, ref_d;
    logic [PERIOD_WIDTH-1:0] period_d;
    logic                    period_valid_d;
    logic [MCW-1:0]          match_cnt_q, match_cnt_d;
    logic [MCW-1:0]          match_inc;
    logic [PERIOD_WIDTH-1:0] diff;
    logic                    match;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_signal (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal_in),
        .q     (sync_signal_in)
    );

    assign rise = sync_signal_in & ~sig_prev_q;

    // ADC strobe edge capture and comparator edge-detect history; both ignore en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_clk_prev_q <= 1'b0;
            sync_adc_data  <= '0;
            sig_prev_q     <= 1'b0;
        end else begin
            adc_clk_prev_q <= adc_clk;
            sig_prev_q     <= sync_signal_in;
            if (adc_clk && !adc_clk_prev_q) begin
                sync_adc_data <= adc_data;
            end
        end
    end

    // Absolute difference without wrap, then the match qualification.
    always_comb begin
        diff  = (counter_q >= ref_q) ? (counter_q - ref_q) : (ref_q - counter_q);
        match = (counter_q >= PERIOD_WIDTH'(MIN_PERIOD)) && (diff <= PERIOD_WIDTH'(TOL));
        match_inc = match_cnt_q + 1'b1;
    end

    // Next-state logic: edge handling takes priority over counter saturation.
    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        ref_d          = ref_q;
        match_cnt_d    = match_cnt_q;
        period_d       = period;
        period_valid_d = 1'b0;

        if (!en) begin
            state_d     = StIdle;
            counter_d   = '0;
            match_cnt_d = '0;
        end else if (state_q == StIdle) begin
            if (rise) begin
                state_d   = StArmed;
                counter_d = PERIOD_WIDTH'(1);
            end
        end else if (rise) begin
            period_d       = counter_q;
            period_valid_d = 1'b1;
            counter_d      = PERIOD_WIDTH'(1);
            ref_d          = counter_q;
            if (state_q == StArmed) begin
                match_cnt_d = '0;
                state_d     = StTracking;
            end else if (state_q == StTracking) begin
                if (match) begin
                    match_cnt_d = match_inc;
                    if (match_inc == MCW'(STABLE_COUNT)) begin
                        state_d = StLocked;
                    end
                end else begin
                    match_cnt_d = '0;
                end
            end else if (!match) begin
                state_d     = StTracking;
                match_cnt_d = '0;
            end
        end else if (counter_q == '1) begin
            // No edge for a full counter span: signal lost.
            state_d     = StIdle;
            counter_d   = '0;
            match_cnt_d = '0;
        end else begin
            counter_d = counter_q + 1'b1;
        end
    end

    // FSM, measurement registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            counter_q    <= '0;
            ref_q        <= '0;
            match_cnt_q  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stable       <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            ref_q        <= ref_d;
            match_cnt_q  <= match_cnt_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            stable       <= (state_d == StLocked);
        end
    end

endmodule

// File: tb/tb_adc_trigger_frontend.sv
// Directed bench for adc_trigger_frontend: square-wave segment tables plus hand sequences.
`timescale 1ns/1ps
module tb_adc_trigger_frontend;

    typedef struct {
        int unsigned len;
        int unsigned exp_period;
        logic        exp_stable;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        adc_clk = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic        signal_in = 1'b0;
    logic [11:0] sync_adc_data;
    logic        sync_signal_in;
    logic        stable;
    logic [15:0] period;
    logic        period_valid;

    int n_checks = 0;
    int n_fail = 0;

    seg_t        tbl[$];
    int unsigned pv_per_q[$];
    logic        pv_st_q[$];
    int unsigned stable_cycles = 0;

    adc_trigger_frontend dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .adc_clk        (adc_clk),
        .adc_data       (adc_data),
        .signal_in      (signal_in),
        .sync_adc_data  (sync_adc_data),
        .sync_signal_in (sync_signal_in),
        .stable         (stable),
        .period         (period),
        .period_valid   (period_valid)
    );

    always #5 clk = ~clk;

    // Record every period_valid pulse with the period and stable seen in that cycle.
    always @(negedge clk) begin
        if (period_valid) begin
            pv_per_q.push_back(int'(period));
            pv_st_q.push_back(stable);
        end
        if (stable) stable_cycles <= stable_cycles + 1;
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic add_seg(input int unsigned len, input int unsigned p, input logic st);
        seg_t s;
        s.len        = len;
        s.exp_period = p;
        s.exp_stable = st;
        tbl.push_back(s);
    endtask

    // One square-wave period of len cycles, starting with a rising edge.
    task automatic run_wave(input int unsigned len);
        signal_in = 1'b1;
        repeat (len / 2) tick();
        signal_in = 1'b0;
        repeat (len - len / 2) tick();
    endtask

    // Drive every segment, close the last one with a trailing edge, then compare pulses.
    task automatic run_table(input string tag);
        int base;
        base = pv_per_q.size();
        foreach (tbl[i]) run_wave(tbl[i].len);
        signal_in = 1'b1;
        repeat (10) tick();
        signal_in = 1'b0;
        check({tag, "_pv_count"}, pv_per_q.size() - base, tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            if (base + i < pv_per_q.size()) begin
                check($sformatf("%s_period[%0d]", tag, i), pv_per_q[base + i], tbl[i].exp_period);
                check($sformatf("%s_stable[%0d]", tag, i), int'(pv_st_q[base + i]),
                      int'(tbl[i].exp_stable));
            end
        end
    endtask

    // Arm, reference, four matches: lock on the sixth edge.
    task automatic lock(input string tag);
        tbl.delete();
        repeat (4) add_seg(100, 100, 1'b0);
        repeat (2) add_seg(100, 100, 1'b1);
        run_table(tag);
    endtask

    initial begin
        int          base;
        int          n;
        int unsigned st0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_sync_adc", int'(sync_adc_data), 0);
        check("rst_sync_sig", int'(sync_signal_in), 0);
        check("rst_stable", int'(stable), 0);
        check("rst_period", int'(period), 0);
        check("rst_pv", int'(period_valid), 0);
        rst_n = 1'b1;
        tick();

        // Two-cycle synchroniser latency.
        signal_in = 1'b1;
        tick();
        check("sync_lat1", int'(sync_signal_in), 0);
        tick();
        check("sync_lat2", int'(sync_signal_in), 1);
        signal_in = 1'b0;
        repeat (3) tick();

        // Lock, tolerance-edge jitter while locked, loss of lock and relock.
        do_reset();
        en = 1'b1;
        tbl.delete();
        repeat (4) add_seg(100, 100, 1'b0);
        repeat (2) add_seg(100, 100, 1'b1);
        add_seg(102, 102, 1'b1);
        add_seg(100, 100, 1'b1);
        add_seg(101, 101, 1'b1);
        add_seg(100, 100, 1'b1);
        add_seg(103, 103, 1'b0);
        repeat (4) add_seg(100, 100, 1'b0);
        add_seg(100, 100, 1'b1);
        run_table("track");

        // Period below MIN_PERIOD never locks.
        do_reset();
        st0 = stable_cycles;
        tbl.delete();
        repeat (8) add_seg(5, 5, 1'b0);
        run_table("short");
        check("short_never_stable", stable_cycles - st0, 0);

        // Enable low forces idle; relock afterwards needs the whole sequence.
        do_reset();
        lock("en_lock");
        check("en_locked", int'(stable), 1);
        en = 1'b0;
        tick();
        check("en_low_stable", int'(stable), 0);
        base = pv_per_q.size();
        repeat (3) run_wave(100);
        check("en_low_no_pv", pv_per_q.size() - base, 0);
        check("en_low_still", int'(stable), 0);
        en = 1'b1;
        lock("en_relock");

        // Asynchronous reset while locked.
        do_reset();
        lock("rst_lock");
        repeat (37) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stable", int'(stable), 0);
        check("arst_period", int'(period), 0);
        check("arst_pv", int'(period_valid), 0);
        check("arst_sync_sig", int'(sync_signal_in), 0);
        check("arst_sync_adc", int'(sync_adc_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        lock("rst_relock");

        // ADC capture on strobe rising edge, held between strobes, independent of en.
        do_reset();
        en = 1'b0;
        adc_data = 12'hABC;
        adc_clk = 1'b1;
        #3;
        check("adc_before_strobe", int'(sync_adc_data), 0);
        tick();
        check("adc_capture", int'(sync_adc_data), 'hABC);
        adc_data = 12'h123;
        tick();
        check("adc_hold_hi", int'(sync_adc_data), 'hABC);
        adc_clk = 1'b0;
        tick();
        check("adc_hold_lo", int'(sync_adc_data), 'hABC);
        tick();
        check("adc_hold_lo2", int'(sync_adc_data), 'hABC);
        adc_data = 12'h456;
        adc_clk = 1'b1;
        tick();
        check("adc_next_strobe", int'(sync_adc_data), 'h456);
        adc_clk = 1'b0;

        // Signal lost while locked: counter saturation returns to idle.
        do_reset();
        en = 1'b1;
        lock("sat_lock");
        base = pv_per_q.size();
        n = 0;
        while (stable && n < 70000) begin
            tick();
            n++;
        end
        if (n < 65520 || n > 65535) begin
            n_fail++;
            $display("FAIL sat_timing: stable dropped after %0d cycles, expected 65520..65535", n);
        end
        n_checks++;
        check("sat_stable", int'(stable), 0);
        check("sat_no_pv", pv_per_q.size() - base, 0);
        check("sat_period_kept", int'(period), 100);
        repeat (20) tick();
        check("sat_no_pv_after", pv_per_q.size() - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
